seq_add_multiplier: RTL and testbench

Sequential 8x8 unsigned multiplier that forms the product by repeated addition. It contains a multiplicand register, a countdown multiplier register, a 16-bit accumulator with its adder, and a control FSM. It sits beside a host that supplies operands and a start pulse, then collects the 16-bit product on a done strobe. Latency scales with the multiplier operand, so this block targets small-area, low-throughput use.

---
 rtl/seq_add_multiplier.sv | 154 +++++++++++++++
 tb/tb_seq_add_multiplier.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/seq_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_add_multiplier
// Description : Sequential 8x8 unsigned multiplier built from repeated
//               addition. A multiplicand register, a countdown multiplier
//               register and a 16-bit accumulator are driven by a four-state
//               control FSM. Latency is B+2 cycles from the sampled start.
//               Optional build macro MULT_OPSWAP_EN loads the larger operand
//               as multiplicand and counts down the smaller one, giving a
//               latency of min(A,B)+2 cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_add_multiplier (
    input  logic        CLK,
    input  logic        RST,
    input  logic        S,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    output logic [15:0] RP,
    output logic        DONE,
    output logic        BUSY
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_ADD  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t       r_state;
    logic [7:0]   r_ra;
    logic [7:0]   r_rb;
    logic [15:0]  r_rp;
    logic         r_done;
    logic         r_busy;

    logic [15:0]  w_sum;
    logic         w_rbzero;
    logic         w_la;
    logic         w_lb;
    logic         w_clrp;
    logic         w_lp;
    logic         w_decb;
    logic [7:0]   w_ld_ra;
    logic [7:0]   w_ld_rb;

    // Accumulator adder; 255*255 fits in 16 bits so no carry-out is needed
    assign w_sum    = {8'b0, r_ra} + r_rp;
    assign w_rbzero = (r_rb == 8'd0);

    // Datapath control strobes decoded from the current state
    assign w_la   = (r_state == ST_LOAD);
    assign w_lb   = (r_state == ST_LOAD);
    assign w_clrp = (r_state == ST_LOAD);
    assign w_lp   = (r_state == ST_ADD) && !w_rbzero;
    assign w_decb = (r_state == ST_ADD) && !w_rbzero;

`ifdef MULT_OPSWAP_EN
    logic w_a_ge_b;

    // Larger operand becomes the multiplicand so the countdown is shortest;
    // on a tie A is taken as the multiplicand
    assign w_a_ge_b = (A >= B);
    assign w_ld_ra  = w_a_ge_b ? A : B;
    assign w_ld_rb  = w_a_ge_b ? B : A;
`else
    // Operands load straight through with no reordering
    assign w_ld_ra  = A;
    assign w_ld_rb  = B;
`endif

    // Control FSM with registered DONE/BUSY outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (S) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_ADD;
                    r_busy  <= 1'b1;
                    r_done  <= 1'b0;
                end
                ST_ADD: begin
                    r_busy <= 1'b1;
                    if (w_rbzero) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_done  <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Multiplicand register: loaded once per operation
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ra <= 8'd0;
        end else if (w_la) begin
            r_ra <= w_ld_ra;
        end
    end

    // Countdown register: loaded with the add count, decremented per add
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rb <= 8'd0;
        end else if (w_lb) begin
            r_rb <= w_ld_rb;
        end else if (w_decb) begin
            r_rb <= r_rb - 8'd1;
        end
    end

    // Accumulator: cleared at load, holds the result until the next load
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rp <= 16'd0;
        end else if (w_clrp) begin
            r_rp <= 16'd0;
        end else if (w_lp) begin
            r_rp <= w_sum;
        end
    end

    assign RP   = r_rp;
    assign DONE = r_done;
    assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_seq_add_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_add_multiplier
// Description : Self-checking bench for seq_add_multiplier. Expected products
//               and latencies come from plain arithmetic on the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_add_multiplier;

    logic        CLK;
    logic        RST;
    logic        S;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [15:0] RP;
    logic        DONE;
    logic        BUSY;

    int total;
    int bad;

    seq_add_multiplier dut (
        .CLK  (CLK),
        .RST  (RST),
        .S    (S),
        .A    (A),
        .B    (B),
        .RP   (RP),
        .DONE (DONE),
        .BUSY (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single comparison point: counts every check and reports mismatches
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Reference: product and edges from the start sample to DONE
    function automatic int ref_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_OPSWAP_EN
        return ((a < b) ? int'(a) : int'(b)) + 2;
`else
        return int'(b) + 2;
`endif
    endfunction

    // Launch one operation and check latency, product and the strobe shape.
    // When disturb is set, S and the operands are scrambled while busy.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit disturb, input string tag);
        int          cyc;
        int          lat;
        logic [15:0] prod;
        prod = 16'(int'(a) * int'(b));
        lat  = ref_lat(a, b);
        @(negedge CLK);
        A = a;
        B = b;
        S = 1'b1;
        @(posedge CLK);
        #1;
        S = 1'b0;
        chk({tag, "_busy"}, BUSY, 1'b1);
        cyc = 0;
        while (cyc < 300) begin
            @(posedge CLK);
            #1;
            cyc++;
            if (DONE) break;
            if (disturb) begin
                A = 8'($urandom);
                B = 8'($urandom);
                S = 1'($urandom);
            end
        end
        S = 1'b0;
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_rp"}, RP, prod);
        chk({tag, "_done"}, DONE, 1'b1);
        @(posedge CLK);
        #1;
        chk({tag, "_done_clr"}, DONE, 1'b0);
        chk({tag, "_idle"}, BUSY, 1'b0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b0;
        S     = 1'b0;
        A     = 8'd0;
        B     = 8'd0;

        // Asynchronous reset asserted between edges
        #2 RST = 1'b1;
        #1;
        chk("rst_rp", RP, 16'd0);
        chk("rst_done", DONE, 1'b0);
        chk("rst_busy", BUSY, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;
        chk("rst_idle", BUSY, 1'b0);

        // Directed cases
        run_op(8'd3,   8'd5,   1'b0, "m3x5");
        run_op(8'd200, 8'd0,   1'b0, "b0");
        run_op(8'd0,   8'd4,   1'b0, "a0");
        run_op(8'd255, 8'd255, 1'b0, "max");
        run_op(8'd5,   8'd3,   1'b0, "m5x3");

        // Start toggles and operand churn while busy must not matter
        run_op(8'd13, 8'd11, 1'b1, "ign");
        repeat (4) begin
            @(posedge CLK);
            #1;
            chk("hold_rp", RP, 16'd143);
            chk("hold_busy", BUSY, 1'b0);
        end

        // Reset in the middle of accumulation
        @(negedge CLK);
        A = 8'd10;
        B = 8'd20;
        S = 1'b1;
        @(posedge CLK);
        #1;
        S = 1'b0;
        repeat (6) @(posedge CLK);
        #3;
        chk("midadd_busy_pre", BUSY, 1'b1);
        RST = 1'b1;
        #1;
        chk("midadd_rp", RP, 16'd0);
        chk("midadd_busy", BUSY, 1'b0);
        chk("midadd_done", DONE, 1'b0);
        @(negedge CLK);
        RST = 1'b0;
        run_op(8'd7, 8'd6, 1'b0, "after_rst");

        // Randomised operands, mostly short countdowns
        for (int i = 0; i < 24; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            ra = 8'($urandom);
            rb = (i % 4 == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            run_op(ra, rb, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
